// File: rtl/dispatch_ctrl_pkg.sv
// dispatch_ctrl_pkg
// Shared types and constants for the instruction-queue / dispatch slice:
// instruction format and operation codes produced by the decoder, base
// opcode constants, the queue FSM state encoding and the encoding legality
// check used on the queue head.
package dispatch_ctrl_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  reg_idx_t;

    typedef enum logic [2:0] {
        TYPE_NONE = 3'd0,
        TYPE_R    = 3'd1,
        TYPE_I    = 3'd2,
        TYPE_S    = 3'd3,
        TYPE_B    = 3'd4,
        TYPE_U    = 3'd5,
        TYPE_J    = 3'd6
    } inst_ty_t;

    typedef enum logic [5:0] {
        OPT_NONE,
        OPT_LUI, OPT_AUIPC, OPT_JAL, OPT_JALR,
        OPT_BEQ, OPT_BNE, OPT_BLT, OPT_BGE, OPT_BLTU, OPT_BGEU,
        OPT_LB, OPT_LH, OPT_LW, OPT_LBU, OPT_LHU,
        OPT_SB, OPT_SH, OPT_SW,
        OPT_ADDI, OPT_SLTI, OPT_SLTIU, OPT_XORI, OPT_ORI, OPT_ANDI,
        OPT_SLLI, OPT_SRLI, OPT_SRAI,
        OPT_ADD, OPT_SUB, OPT_SLL, OPT_SLT, OPT_SLTU,
        OPT_XOR, OPT_SRL, OPT_SRA, OPT_OR, OPT_AND
    } inst_opt_t;

    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_JAL    = 7'h6f;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_OP     = 7'h33;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } iq_state_t;

    // The decoder produces nothing meaningful for unknown encodings, so the
    // queue decides legality itself from opcode and funct3.
    function automatic logic is_legal(input word_t inst);
        logic [2:0] f3;
        logic       ok;
        f3 = inst[14:12];
        case (inst[6:0])
            OPC_LUI, OPC_AUIPC, OPC_JAL,
            OPC_OP_IMM, OPC_OP: ok = 1'b1;
            OPC_JALR:           ok = (f3 == 3'd0);
            OPC_BRANCH:         ok = (f3 != 3'd2) && (f3 != 3'd3);
            OPC_LOAD:           ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) ||
                                     (f3 == 3'd4) || (f3 == 3'd5);
            OPC_STORE:          ok = (f3 <= 3'd2);
            default:            ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dispatch_ctrl_if.sv
// dispatch_ctrl_if
// Fetch-side and back-end-side handshake bundle of the dispatch controller.
//   fetch : if_valid, if_inst, if_pc -> ; <- if_ready
//   credit: rob_ready, rs_ready, lsb_ready ->
//   issue : <- dsp_rs_valid, dsp_lsb_valid, dsp_ty, dsp_opt,
//            dsp_rd, dsp_rs1, dsp_rs2, dsp_imm, dsp_pc
// slave is the dispatch controller, master is its surroundings.
interface dispatch_ctrl_if;
    import dispatch_ctrl_pkg::*;

    logic      if_valid;
    word_t     if_inst;
    word_t     if_pc;
    logic      if_ready;
    logic      rob_ready;
    logic      rs_ready;
    logic      lsb_ready;
    logic      dsp_rs_valid;
    logic      dsp_lsb_valid;
    inst_ty_t  dsp_ty;
    inst_opt_t dsp_opt;
    reg_idx_t  dsp_rd;
    reg_idx_t  dsp_rs1;
    reg_idx_t  dsp_rs2;
    word_t     dsp_imm;
    word_t     dsp_pc;

    modport slave (
        input  if_valid, if_inst, if_pc, rob_ready, rs_ready, lsb_ready,
        output if_ready, dsp_rs_valid, dsp_lsb_valid, dsp_ty, dsp_opt,
               dsp_rd, dsp_rs1, dsp_rs2, dsp_imm, dsp_pc
    );

    modport master (
        output if_valid, if_inst, if_pc, rob_ready, rs_ready, lsb_ready,
        input  if_ready, dsp_rs_valid, dsp_lsb_valid, dsp_ty, dsp_opt,
               dsp_rd, dsp_rs1, dsp_rs2, dsp_imm, dsp_pc
    );

endinterface

// File: rtl/dispatch_ctrl_decoder.sv
// decoder
// Purely combinational RV32I decoder.
//   inst  in  32  instruction word
//   ty    out     instruction format
//   opt   out     operation
//   rd/rs1/rs2    register indices (0 where the format has none)
//   imm   out 32  sign-extended immediate
//   is_ls out 1   load or store (routes to the load/store buffer)
module decoder
    import dispatch_ctrl_pkg::*;
(
    input  word_t     inst,
    output inst_ty_t  ty,
    output inst_opt_t opt,
    output reg_idx_t  rd,
    output reg_idx_t  rs1,
    output reg_idx_t  rs2,
    output word_t     imm,
    output logic      is_ls
);

    logic [2:0] f3;
    logic       f7_alt;

    assign f3     = inst[14:12];
    assign f7_alt = inst[30];

    always_comb begin
        ty  = TYPE_NONE;
        opt = OPT_NONE;
        case (inst[6:0])
            OPC_LUI:   begin ty = TYPE_U; opt = OPT_LUI;   end
            OPC_AUIPC: begin ty = TYPE_U; opt = OPT_AUIPC; end
            OPC_JAL:   begin ty = TYPE_J; opt = OPT_JAL;   end
            OPC_JALR:  begin ty = TYPE_I; opt = OPT_JALR;  end
            OPC_BRANCH: begin
                ty = TYPE_B;
                case (f3)
                    3'd0:    opt = OPT_BEQ;
                    3'd1:    opt = OPT_BNE;
                    3'd4:    opt = OPT_BLT;
                    3'd5:    opt = OPT_BGE;
                    3'd6:    opt = OPT_BLTU;
                    3'd7:    opt = OPT_BGEU;
                    default: opt = OPT_NONE;
                endcase
            end
            OPC_LOAD: begin
                ty = TYPE_I;
                case (f3)
                    3'd0:    opt = OPT_LB;
                    3'd1:    opt = OPT_LH;
                    3'd2:    opt = OPT_LW;
                    3'd4:    opt = OPT_LBU;
                    3'd5:    opt = OPT_LHU;
                    default: opt = OPT_NONE;
                endcase
            end
            OPC_STORE: begin
                ty = TYPE_S;
                case (f3)
                    3'd0:    opt = OPT_SB;
                    3'd1:    opt = OPT_SH;
                    3'd2:    opt = OPT_SW;
                    default: opt = OPT_NONE;
                endcase
            end
            OPC_OP_IMM: begin
                ty = TYPE_I;
                case (f3)
                    3'd0: opt = OPT_ADDI;
                    3'd1: opt = OPT_SLLI;
                    3'd2: opt = OPT_SLTI;
                    3'd3: opt = OPT_SLTIU;
                    3'd4: opt = OPT_XORI;
                    3'd5: opt = f7_alt ? OPT_SRAI : OPT_SRLI;
                    3'd6: opt = OPT_ORI;
                    default: opt = OPT_ANDI;
                endcase
            end
            OPC_OP: begin
                ty = TYPE_R;
                case (f3)
                    3'd0: opt = f7_alt ? OPT_SUB : OPT_ADD;
                    3'd1: opt = OPT_SLL;
                    3'd2: opt = OPT_SLT;
                    3'd3: opt = OPT_SLTU;
                    3'd4: opt = OPT_XOR;
                    3'd5: opt = f7_alt ? OPT_SRA : OPT_SRL;
                    3'd6: opt = OPT_OR;
                    default: opt = OPT_AND;
                endcase
            end
            default: begin
                ty  = TYPE_NONE;
                opt = OPT_NONE;
            end
        endcase
    end

    always_comb begin
        rd  = ((ty == TYPE_S) || (ty == TYPE_B) || (ty == TYPE_NONE)) ? 5'd0 : inst[11:7];
        rs1 = ((ty == TYPE_U) || (ty == TYPE_J) || (ty == TYPE_NONE)) ? 5'd0 : inst[19:15];
        rs2 = ((ty == TYPE_R) || (ty == TYPE_S) || (ty == TYPE_B))    ? inst[24:20] : 5'd0;
        case (ty)
            TYPE_I:  imm = {{20{inst[31]}}, inst[31:20]};
            TYPE_S:  imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            TYPE_B:  imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            TYPE_U:  imm = {inst[31:12], 12'd0};
            TYPE_J:  imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm = 32'd0;
        endcase
    end

    assign is_ls = (inst[6:0] == OPC_LOAD) || (inst[6:0] == OPC_STORE);

endmodule

// File: rtl/dispatch_ctrl.sv
// dispatch_ctrl
// Instruction queue between fetch and the out-of-order back end. Fetched
// {inst, pc} pairs are buffered in a circular FIFO; the head is decoded and
// dispatched to the RS or LSB when the ROB and the target unit have room.
// A mispredict flush empties the queue; an illegal head halts dispatch.
//   clk, rst_n   clock, asynchronous active-low reset
//   rdy          global enable; nothing changes state while low
//   flush        mispredict flush from the ROB
//   bus          fetch / credit / dispatch bundle (slave side)
//   ill_inst     sticky: illegal encoding reached the queue head
module dispatch_ctrl
    import dispatch_ctrl_pkg::*;
#(
    parameter int IQ_DEPTH = 4,
    parameter int IQ_IDX_W = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rdy,
    input  logic            flush,
    dispatch_ctrl_if.slave  bus,
    output logic            ill_inst
);

    localparam logic [IQ_IDX_W:0] PTR_ONE = (IQ_IDX_W + 1)'(1);

    // One extra pointer bit distinguishes full from empty.
    logic [IQ_IDX_W:0] rd_ptr;
    logic [IQ_IDX_W:0] wr_ptr;
    word_t             iq_inst [IQ_DEPTH];
    word_t             iq_pc   [IQ_DEPTH];

    iq_state_t state_q;
    iq_state_t state_d;
    logic      run_en;

    logic      empty;
    logic      full;
    logic      enq;
    logic      fire;
    logic      head_legal;
    logic      target_ready;
    word_t     head_inst;
    word_t     head_pc;

    inst_ty_t  dec_ty;
    inst_opt_t dec_opt;
    reg_idx_t  dec_rd;
    reg_idx_t  dec_rs1;
    reg_idx_t  dec_rs2;
    word_t     dec_imm;
    logic      dec_is_ls;

    assign empty = (rd_ptr == wr_ptr);
    assign full  = (rd_ptr[IQ_IDX_W-1:0] == wr_ptr[IQ_IDX_W-1:0]) &&
                   (rd_ptr[IQ_IDX_W] != wr_ptr[IQ_IDX_W]);

    // Registered-state only: a full queue refuses input even if it drains
    // this cycle, which keeps if_ready off the dispatch timing path.
    assign bus.if_ready = !full;

    assign head_inst = iq_inst[rd_ptr[IQ_IDX_W-1:0]];
    assign head_pc   = iq_pc[rd_ptr[IQ_IDX_W-1:0]];

    decoder u_decoder (
        .inst  (head_inst),
        .ty    (dec_ty),
        .opt   (dec_opt),
        .rd    (dec_rd),
        .rs1   (dec_rs1),
        .rs2   (dec_rs2),
        .imm   (dec_imm),
        .is_ls (dec_is_ls)
    );

    assign head_legal   = is_legal(head_inst);
    assign target_ready = dec_is_ls ? bus.lsb_ready : bus.rs_ready;

    assign enq  = bus.if_valid && !full && rdy && !flush;
    assign fire = run_en && !empty && rdy && !flush && head_legal &&
                  bus.rob_ready && target_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Flush has priority; the head's legality only counts when the queue
    // holds something, since an empty slot carries stale data.
    always_comb begin
        state_d = state_q;
        if (rdy) begin
            if (flush) begin
                state_d = ST_RUN;
            end else if ((state_q == ST_RUN) && !empty && !head_legal) begin
                state_d = ST_HALT;
            end
        end
    end

    always_comb begin
        ill_inst = (state_q == ST_HALT);
        run_en   = (state_q == ST_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (rdy) begin
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (enq)  wr_ptr <= wr_ptr + PTR_ONE;
                if (fire) rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (enq) begin
            iq_inst[wr_ptr[IQ_IDX_W-1:0]] <= bus.if_inst;
            iq_pc[wr_ptr[IQ_IDX_W-1:0]]   <= bus.if_pc;
        end
    end

    // Valid strobes last one cycle; data fields hold between dispatches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.dsp_rs_valid  <= 1'b0;
            bus.dsp_lsb_valid <= 1'b0;
            bus.dsp_ty        <= TYPE_NONE;
            bus.dsp_opt       <= OPT_NONE;
            bus.dsp_rd        <= '0;
            bus.dsp_rs1       <= '0;
            bus.dsp_rs2       <= '0;
            bus.dsp_imm       <= '0;
            bus.dsp_pc        <= '0;
        end else if (fire) begin
            bus.dsp_rs_valid  <= !dec_is_ls;
            bus.dsp_lsb_valid <= dec_is_ls;
            bus.dsp_ty        <= dec_ty;
            bus.dsp_opt       <= dec_opt;
            bus.dsp_rd        <= dec_rd;
            bus.dsp_rs1       <= dec_rs1;
            bus.dsp_rs2       <= dec_rs2;
            bus.dsp_imm       <= dec_imm;
            bus.dsp_pc        <= head_pc;
        end else begin
            bus.dsp_rs_valid  <= 1'b0;
            bus.dsp_lsb_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dispatch_ctrl.sv
// tb_dispatch_ctrl
// Directed bench for dispatch_ctrl: reset values, single RS and LSB
// dispatch, full-queue backpressure and drain order, flush, illegal-head
// halt, global enable hold and asynchronous reset mid-stream.
module tb_dispatch_ctrl;
    import dispatch_ctrl_pkg::*;

    logic clk;
    logic rst_n;
    logic rdy;
    logic flush;
    logic ill_inst;

    int vectors;
    int miscompares;

    dispatch_ctrl_if dif ();

    dispatch_ctrl #(
        .IQ_DEPTH (4),
        .IQ_IDX_W (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rdy      (rdy),
        .flush    (flush),
        .bus      (dif.slave),
        .ill_inst (ill_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Outputs are sampled and inputs changed 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic word_t addi(input int rd, input int imm);
        return word_t'((imm << 20) | (rd << 7) | 32'h13);
    endfunction

    task automatic push_set(input word_t inst, input word_t pc);
        dif.if_valid = 1'b1;
        dif.if_inst  = inst;
        dif.if_pc    = pc;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rdy = 1'b1;
        flush = 1'b0;
        dif.if_valid = 1'b0;
        dif.if_inst = '0;
        dif.if_pc = '0;
        dif.rob_ready = 1'b1;
        dif.rs_ready = 1'b1;
        dif.lsb_ready = 1'b1;
        tick();
        tick();
        vectors++; if (dif.if_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_if_ready got %b exp 1", dif.if_ready); end
        vectors++; if ({dif.dsp_rs_valid, dif.dsp_lsb_valid} !== 2'b00) begin miscompares++; $display("[TB] FAIL reset_valids got %b exp 00", {dif.dsp_rs_valid, dif.dsp_lsb_valid}); end
        vectors++; if (ill_inst !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ill got %b exp 0", ill_inst); end
        vectors++; if (dif.dsp_pc !== 32'd0) begin miscompares++; $display("[TB] FAIL reset_pc got %h exp 0", dif.dsp_pc); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_rs_dispatch();
        push_set(32'h00500093, 32'h100);
        tick();
        dif.if_valid = 1'b0;
        vectors++; if (dif.dsp_rs_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rs_no_bypass got %b exp 0", dif.dsp_rs_valid); end
        tick();
        vectors++; if (dif.dsp_rs_valid !== 1'b1 || dif.dsp_lsb_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rs_pulse got rs=%b lsb=%b exp rs=1 lsb=0", dif.dsp_rs_valid, dif.dsp_lsb_valid); end
        vectors++; if (dif.dsp_opt !== OPT_ADDI || dif.dsp_ty !== TYPE_I) begin miscompares++; $display("[TB] FAIL rs_opt got opt=%0d ty=%0d exp opt=%0d ty=%0d", dif.dsp_opt, dif.dsp_ty, OPT_ADDI, TYPE_I); end
        vectors++; if (dif.dsp_rd !== 5'd1 || dif.dsp_rs1 !== 5'd0) begin miscompares++; $display("[TB] FAIL rs_regs got rd=%0d rs1=%0d exp rd=1 rs1=0", dif.dsp_rd, dif.dsp_rs1); end
        vectors++; if (dif.dsp_imm !== 32'd5 || dif.dsp_pc !== 32'h100) begin miscompares++; $display("[TB] FAIL rs_imm_pc got imm=%h pc=%h exp imm=5 pc=100", dif.dsp_imm, dif.dsp_pc); end
        tick();
        vectors++; if (dif.dsp_rs_valid !== 1'b0 || dif.dsp_pc !== 32'h100) begin miscompares++; $display("[TB] FAIL rs_hold got valid=%b pc=%h exp valid=0 pc=100", dif.dsp_rs_valid, dif.dsp_pc); end
    endtask

    task automatic test_lsb_dispatch();
        dif.lsb_ready = 1'b0;
        push_set(32'h0080a103, 32'h104);
        tick();
        dif.if_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++; if ({dif.dsp_rs_valid, dif.dsp_lsb_valid} !== 2'b00) begin miscompares++; $display("[TB] FAIL lsb_wait%0d got %b exp 00", i, {dif.dsp_rs_valid, dif.dsp_lsb_valid}); end
        end
        dif.lsb_ready = 1'b1;
        tick();
        vectors++; if (dif.dsp_lsb_valid !== 1'b1 || dif.dsp_rs_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL lsb_pulse got lsb=%b rs=%b exp lsb=1 rs=0", dif.dsp_lsb_valid, dif.dsp_rs_valid); end
        vectors++; if (dif.dsp_opt !== OPT_LW || dif.dsp_imm !== 32'd8) begin miscompares++; $display("[TB] FAIL lsb_fields got opt=%0d imm=%h exp opt=%0d imm=8", dif.dsp_opt, dif.dsp_imm, OPT_LW); end
        vectors++; if (dif.dsp_rd !== 5'd2 || dif.dsp_rs1 !== 5'd1 || dif.dsp_pc !== 32'h104) begin miscompares++; $display("[TB] FAIL lsb_regs got rd=%0d rs1=%0d pc=%h exp rd=2 rs1=1 pc=104", dif.dsp_rd, dif.dsp_rs1, dif.dsp_pc); end
        tick();
    endtask

    task automatic test_back_to_back();
        word_t exp_pc;
        dif.rob_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_set(addi(i + 1, i + 1), 32'h200 + 32'(4 * i));
            vectors++; if (dif.if_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL fill_ready%0d got %b exp 1", i, dif.if_ready); end
            tick();
        end
        push_set(addi(5, 5), 32'h210);
        vectors++; if (dif.if_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL full_ready got %b exp 0", dif.if_ready); end
        tick();
        vectors++; if (dif.if_ready !== 1'b0 || dif.dsp_rs_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL full_hold got ready=%b valid=%b exp 0 0", dif.if_ready, dif.dsp_rs_valid); end
        dif.rob_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (k == 1) dif.if_valid = 1'b0;
            exp_pc = 32'h200 + 32'(4 * k);
            vectors++; if (dif.dsp_rs_valid !== 1'b1 || dif.dsp_pc !== exp_pc || dif.dsp_rd !== 5'(k + 1)) begin miscompares++; $display("[TB] FAIL drain%0d got valid=%b pc=%h rd=%0d exp valid=1 pc=%h rd=%0d", k, dif.dsp_rs_valid, dif.dsp_pc, dif.dsp_rd, exp_pc, k + 1); end
        end
        tick();
        vectors++; if (dif.dsp_rs_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL drain_end got %b exp 0", dif.dsp_rs_valid); end
    endtask

    task automatic test_flush();
        dif.rob_ready = 1'b0;
        push_set(addi(3, 3), 32'h300);
        tick();
        push_set(addi(4, 4), 32'h304);
        tick();
        flush = 1'b1;
        dif.rob_ready = 1'b1;
        push_set(addi(7, 7), 32'h400);
        tick();
        vectors++; if (dif.dsp_rs_valid !== 1'b0 || dif.if_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL flush_edge got valid=%b ready=%b exp 0 1", dif.dsp_rs_valid, dif.if_ready); end
        flush = 1'b0;
        tick();
        dif.if_valid = 1'b0;
        vectors++; if (dif.dsp_rs_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_empty got %b exp 0", dif.dsp_rs_valid); end
        tick();
        vectors++; if (dif.dsp_rs_valid !== 1'b1 || dif.dsp_pc !== 32'h400 || dif.dsp_rd !== 5'd7) begin miscompares++; $display("[TB] FAIL flush_new got valid=%b pc=%h rd=%0d exp 1 400 7", dif.dsp_rs_valid, dif.dsp_pc, dif.dsp_rd); end
        tick();
    endtask

    task automatic test_illegal();
        push_set(32'hffffffff, 32'h500);
        tick();
        vectors++; if (ill_inst !== 1'b0) begin miscompares++; $display("[TB] FAIL ill_early got %b exp 0", ill_inst); end
        push_set(addi(8, 8), 32'h504);
        tick();
        dif.if_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vectors++; if (ill_inst !== 1'b1 || {dif.dsp_rs_valid, dif.dsp_lsb_valid} !== 2'b00) begin miscompares++; $display("[TB] FAIL ill_halt%0d got ill=%b valids=%b exp ill=1 valids=00", i, ill_inst, {dif.dsp_rs_valid, dif.dsp_lsb_valid}); end
            tick();
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        vectors++; if (ill_inst !== 1'b0 || dif.dsp_rs_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL ill_clear got ill=%b valid=%b exp 0 0", ill_inst, dif.dsp_rs_valid); end
        push_set(addi(9, 9), 32'h600);
        tick();
        dif.if_valid = 1'b0;
        tick();
        vectors++; if (dif.dsp_rs_valid !== 1'b1 || dif.dsp_pc !== 32'h600) begin miscompares++; $display("[TB] FAIL ill_rerun got valid=%b pc=%h exp 1 600", dif.dsp_rs_valid, dif.dsp_pc); end
        tick();
    endtask

    task automatic test_rdy_and_reset();
        dif.rob_ready = 1'b0;
        push_set(addi(10, 10), 32'h700);
        tick();
        dif.rob_ready = 1'b1;
        rdy = 1'b0;
        push_set(addi(11, 11), 32'h704);
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++; if (dif.dsp_rs_valid !== 1'b0 || dif.if_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL rdy_hold%0d got valid=%b ready=%b exp 0 1", i, dif.dsp_rs_valid, dif.if_ready); end
        end
        rdy = 1'b1;
        dif.if_valid = 1'b0;
        tick();
        vectors++; if (dif.dsp_rs_valid !== 1'b1 || dif.dsp_pc !== 32'h700) begin miscompares++; $display("[TB] FAIL rdy_resume got valid=%b pc=%h exp 1 700", dif.dsp_rs_valid, dif.dsp_pc); end
        tick();
        vectors++; if (dif.dsp_rs_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rdy_no_enq got %b exp 0", dif.dsp_rs_valid); end

        push_set(addi(12, 12), 32'h800);
        tick();
        push_set(addi(13, 13), 32'h804);
        tick();
        dif.if_valid = 1'b0;
        vectors++; if (dif.dsp_rs_valid !== 1'b1 || dif.dsp_pc !== 32'h800) begin miscompares++; $display("[TB] FAIL pre_rst got valid=%b pc=%h exp 1 800", dif.dsp_rs_valid, dif.dsp_pc); end
        #1 rst_n = 1'b0;
        #1;
        vectors++; if (dif.dsp_rs_valid !== 1'b0 || dif.dsp_pc !== 32'd0 || dif.dsp_rd !== 5'd0 || dif.dsp_opt !== OPT_NONE) begin miscompares++; $display("[TB] FAIL async_rst got valid=%b pc=%h rd=%0d opt=%0d exp 0 0 0 0", dif.dsp_rs_valid, dif.dsp_pc, dif.dsp_rd, dif.dsp_opt); end
        tick();
        rst_n = 1'b1;
        vectors++; if (dif.if_ready !== 1'b1 || ill_inst !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_release got ready=%b ill=%b exp 1 0", dif.if_ready, ill_inst); end
        tick();
        vectors++; if (dif.dsp_rs_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_dropped got %b exp 0", dif.dsp_rs_valid); end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_rs_dispatch();
        test_lsb_dispatch();
        test_back_to_back();
        test_flush();
        test_illegal();
        test_rdy_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
